// File: rtl/pwm_deadtime_gen.sv
// Complementary gate driver with dead-time insertion, latched fault shutdown
// and a saturating counter of PWM pulses too short to pass the dead band.
module pwm_deadtime_gen #(
    parameter int DT_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    input  logic [DT_W-1:0]  dead_time,
    input  logic             fault_in,
    input  logic             fault_clear,
    output logic             out_hi,
    output logic             out_lo,
    output logic             fault_latched,
    output logic [CNT_W-1:0] short_pulse_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DT_HI = 3'd1,
        HI    = 3'd2,
        DT_LO = 3'd3,
        LO    = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DT_W-1:0]  cnt;
    logic [DT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0] spc_nxt;
    logic             hi_nxt;
    logic             lo_nxt;
    logic             fl_nxt;
    logic             fault_meta;
    logic             fault_s;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Two-flop synchronizer for the asynchronous fault pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_meta <= 1'b0;
            fault_s    <= 1'b0;
        end else begin
            fault_meta <= fault_in;
            fault_s    <= fault_meta;
        end
    end

    // Next-state decode: fault beats enable, enable beats per-state rules.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        spc_nxt   = short_pulse_cnt;
        if (fault_s) begin
            state_nxt = FAULT;
        end else if (state != FAULT && !enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = pwm_in ? DT_HI : DT_LO;
                    cnt_nxt   = dead_time;
                end
                DT_HI: begin
                    if (!pwm_in) begin
                        // Pulse ended before the dead band expired: abort it.
                        state_nxt = DT_LO;
                        cnt_nxt   = dead_time;
                        spc_nxt   = sat_inc(short_pulse_cnt);
                    end else if (cnt == '0) begin
                        state_nxt = HI;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end
                DT_LO: begin
                    if (pwm_in) begin
                        state_nxt = DT_HI;
                        cnt_nxt   = dead_time;
                        spc_nxt   = sat_inc(short_pulse_cnt);
                    end else if (cnt == '0) begin
                        state_nxt = LO;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end
                HI: begin
                    if (!pwm_in) begin
                        state_nxt = DT_LO;
                        cnt_nxt   = dead_time;
                    end
                end
                LO: begin
                    if (pwm_in) begin
                        state_nxt = DT_HI;
                        cnt_nxt   = dead_time;
                    end
                end
                FAULT: begin
                    // Reaching here implies fault_s is already low.
                    if (fault_clear) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
        hi_nxt = (state_nxt == HI);
        lo_nxt = (state_nxt == LO);
        fl_nxt = (state_nxt == FAULT);
    end

    // State, counters and registered outputs update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            short_pulse_cnt <= '0;
            out_hi          <= 1'b0;
            out_lo          <= 1'b0;
            fault_latched   <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            short_pulse_cnt <= spc_nxt;
            out_hi          <= hi_nxt;
            out_lo          <= lo_nxt;
            fault_latched   <= fl_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Scoreboard bench for pwm_deadtime_gen: stimulus pushes hand-computed
// expectations tagged with an edge number; a monitor pops and compares them.
module tb_pwm_deadtime_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pwm_in;
    logic [7:0] dead_time;
    logic       fault_in;
    logic       fault_clear;
    logic       out_hi;
    logic       out_lo;
    logic       fault_latched;
    logic [7:0] short_pulse_cnt;

    typedef struct {
        int         cyc;
        logic       hi;
        logic       lo;
        logic       fl;
        logic [7:0] spc;
        string      name;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_spc;

    pwm_deadtime_gen #(.DT_W(8), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .pwm_in         (pwm_in),
        .dead_time      (dead_time),
        .fault_in       (fault_in),
        .fault_clear    (fault_clear),
        .out_hi         (out_hi),
        .out_lo         (out_lo),
        .fault_latched  (fault_latched),
        .short_pulse_cnt(short_pulse_cnt)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input logic h, input logic l,
                                 input logic f, input logic [7:0] s, input string nm);
        exp_t e;
        e.cyc = c; e.hi = h; e.lo = l; e.fl = f; e.spc = s; e.name = nm;
        q.push_back(e);
    endfunction

    // Monitor: every cycle check overlap, then retire expectations due now.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset === 1'b0) begin
                checks++;
                if ((out_hi & out_lo) === 1'b1) begin
                    errors++;
                    $display("FAIL overlap @cyc %0d: hi=%b lo=%b, required not both 1", cyc, out_hi, out_lo);
                end
            end
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (e.cyc < cyc) begin
                    errors++;
                    $display("FAIL %s missed: due cyc %0d, now %0d", e.name, e.cyc, cyc);
                end else if (out_hi !== e.hi || out_lo !== e.lo ||
                             fault_latched !== e.fl || short_pulse_cnt !== e.spc) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: hi/lo/flt/spc got %b%b%b/%0d, required %b%b%b/%0d",
                             e.name, cyc, out_hi, out_lo, fault_latched, short_pulse_cnt,
                             e.hi, e.lo, e.fl, e.spc);
                end
            end
        end
    end

    // Drive pwm_in to val and expect dt+1 both-low cycles then the matching drive.
    task automatic pwm_edge(input logic val, input int dt, input int hold);
        int n;
        pwm_in = val;
        n = cyc + 1;
        push(n, 1'b0, 1'b0, 1'b0, exp_spc, "dt_start");
        if (dt > 0) push(n + dt, 1'b0, 1'b0, 1'b0, exp_spc, "dt_end");
        push(n + dt + 1, val, !val, 1'b0, exp_spc, "drive");
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; pwm_in = 1'b0; dead_time = 8'd3;
        fault_in = 1'b0; fault_clear = 1'b0; exp_spc = 8'd0;

        repeat (2) @(negedge clk);
        push(cyc + 1, 1'b0, 1'b0, 1'b0, 8'd0, "reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Complementary drive, dead_time=3, 20-cycle period.
        enable = 1'b1;
        pwm_edge(1'b0, 3, 10);
        for (int i = 0; i < 3; i++) begin
            pwm_edge(1'b1, 3, 10);
            pwm_edge(1'b0, 3, 10);
        end

        // Zero dead time: single both-low cycle per transition.
        dead_time = 8'd0;
        for (int i = 0; i < 2; i++) begin
            pwm_edge(1'b1, 0, 5);
            pwm_edge(1'b0, 0, 5);
        end

        // Short pulse: 2-cycle high with dead_time=5 from LO.
        dead_time = 8'd5;
        pwm_in = 1'b1;
        n = cyc + 1;
        for (int k = 0; k <= 8; k++)
            push(n + k, 1'b0, (k == 8), 1'b0, (k >= 2) ? 8'd1 : 8'd0, "short_pulse");
        exp_spc = 8'd1;
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        repeat (8) @(negedge clk);

        // Saturation sweep: toggling every cycle aborts every dead-time phase.
        pwm_in = 1'b1;
        n = cyc + 1;
        push(n + 253, 1'b0, 1'b0, 1'b0, 8'd254, "sat_254");
        push(n + 254, 1'b0, 1'b0, 1'b0, 8'd255, "sat_255");
        push(n + 300, 1'b0, 1'b0, 1'b0, 8'd255, "sat_stick");
        exp_spc = 8'd255;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            pwm_in = ~pwm_in;
        end
        @(negedge clk);
        pwm_in = 1'b0;
        push(cyc + 10, 1'b0, 1'b1, 1'b0, 8'd255, "sat_hold");
        repeat (10) @(negedge clk);

        // Fault from HI.
        dead_time = 8'd3;
        pwm_edge(1'b1, 3, 8);
        fault_in = 1'b1;
        n = cyc + 1;
        push(n + 1, 1'b1, 1'b0, 1'b0, exp_spc, "pre_fault");
        push(n + 2, 1'b0, 1'b0, 1'b1, exp_spc, "fault_entry");
        repeat (3) @(negedge clk);
        fault_clear = 1'b1;
        push(cyc + 3, 1'b0, 1'b0, 1'b1, exp_spc, "clear_ignored");
        repeat (3) @(negedge clk);
        fault_clear = 1'b0;
        fault_in = 1'b0;
        push(cyc + 3, 1'b0, 1'b0, 1'b1, exp_spc, "fault_held");
        repeat (3) @(negedge clk);
        fault_clear = 1'b1;
        n = cyc + 1;
        push(n, 1'b0, 1'b0, 1'b0, exp_spc, "fault_exit");
        push(n + 4, 1'b0, 1'b0, 1'b0, exp_spc, "dt_after_fault");
        push(n + 5, 1'b1, 1'b0, 1'b0, exp_spc, "drive_after_fault");
        @(negedge clk);
        fault_clear = 1'b0;
        repeat (7) @(negedge clk);

        // Enable drop in DT_HI with cnt=2.
        pwm_edge(1'b0, 3, 8);
        pwm_in = 1'b1;
        n = cyc + 1;
        push(n + 1, 1'b0, 1'b0, 1'b0, exp_spc, "dt_hi_cnt2");
        repeat (2) @(negedge clk);
        enable = 1'b0;
        for (int k = 2; k <= 6; k++) push(n + k, 1'b0, 1'b0, 1'b0, exp_spc, "enable_off");
        repeat (5) @(negedge clk);
        enable = 1'b1;
        pwm_edge(1'b1, 3, 8);

        // Reset in DT_HI with cnt=2.
        pwm_edge(1'b0, 3, 8);
        pwm_in = 1'b1;
        n = cyc + 1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_spc = 8'd0;
        push(n + 2, 1'b0, 1'b0, 1'b0, 8'd0, "reset_mid");
        push(n + 3, 1'b0, 1'b0, 1'b0, 8'd0, "reset_hold");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pwm_edge(1'b1, 3, 8);

        // Dead-time change from 7 to 1 during a phase.
        dead_time = 8'd7;
        pwm_in = 1'b0;
        n = cyc + 1;
        push(n, 1'b0, 1'b0, 1'b0, exp_spc, "dt7_start");
        push(n + 7, 1'b0, 1'b0, 1'b0, exp_spc, "dt7_end");
        push(n + 8, 1'b0, 1'b1, 1'b0, exp_spc, "dt7_drive");
        repeat (3) @(negedge clk);
        dead_time = 8'd1;
        repeat (8) @(negedge clk);
        pwm_edge(1'b1, 1, 6);

        repeat (20) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
